// File: rtl/cr_axi4s_fanout_buf_pkg.sv
// Shared types for the AXI4-stream fanout: lossy tap state and FIFO pointer sizing.
// No logic here, so there is no latency or backpressure.
package cr_axi4s_fanout_buf_pkg;

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } lossy_state_e;

    // Pointer and count width for a FIFO of the given depth.
    // The extra top bit is the wrap flag that separates full from empty.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cr_axi4s_fanout_fifo.sv
// Per-output FIFO: register array with wrap-bit pointers; one cycle from push to dout.
// A push while full is ignored, and a pop while empty is ignored.
module cr_axi4s_fanout_fifo
    import cr_axi4s_fanout_buf_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

endmodule

// File: rtl/cr_axi4s_fanout_buf.sv
// N-way AXI4-stream fanout with per-output FIFOs; a beat is visible at outputs one cycle after acceptance.
// Lossless outputs stall the source when full; lossy outputs drop the frame tail instead.
module cr_axi4s_fanout_buf
    import cr_axi4s_fanout_buf_pkg::*;
#(
    parameter int N_OUTPUTS   = 2,
    parameter int PAYLD_WIDTH = 64,
    parameter int TLAST_BIT   = 0,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_src,
    input  logic [PAYLD_WIDTH-1:0]           payload_src,
    output logic                             ready_src,
    output logic [N_OUTPUTS-1:0]             valid_dst,
    output logic [N_OUTPUTS*PAYLD_WIDTH-1:0] payload_dst,
    input  logic [N_OUTPUTS-1:0]             ready_dst,
    input  logic [N_OUTPUTS-1:0]             cfg_enable,
    input  logic [N_OUTPUTS-1:0]             cfg_lossy,
    output logic [N_OUTPUTS*CNT_W-1:0]       drop_cnt,
    output logic [N_OUTPUTS-1:0]             drop_event
);

    logic                 rst_done;
    logic                 in_frame;
    logic                 accept;
    logic                 tlast;
    logic [N_OUTPUTS-1:0] active_en;
    logic [N_OUTPUTS-1:0] lossy_act;
    logic [N_OUTPUTS-1:0] full;
    logic [N_OUTPUTS-1:0] empty;
    logic [N_OUTPUTS-1:0] push;
    logic [N_OUTPUTS-1:0] drop;
    logic [N_OUTPUTS-1:0] blocking;
    logic [N_OUTPUTS-1:0] event_q;
    lossy_state_e         state [N_OUTPUTS];
    logic [CNT_W-1:0]     cnt   [N_OUTPUTS];

    // full comes straight from FIFO pointers, so ready_dst never reaches ready_src combinationally.
    assign blocking   = active_en & ~lossy_act & full;
    assign ready_src  = rst_done & ~(|blocking);
    assign accept     = valid_src & ready_src;
    assign tlast      = payload_src[TLAST_BIT];
    assign drop_event = event_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done  <= 1'b0;
            in_frame  <= 1'b0;
            active_en <= '0;
            lossy_act <= '0;
        end else begin
            rst_done <= 1'b1;
            if (accept) begin
                in_frame <= ~tlast;
            end
            // Config only moves between frames, so no output ever sees a partial frame.
            if (!in_frame && !accept) begin
                active_en <= cfg_enable;
                lossy_act <= cfg_lossy;
            end
        end
    end

    for (genvar i = 0; i < N_OUTPUTS; i++) begin : g_out
        assign push[i] = accept & active_en[i] &
                         (~lossy_act[i] | ((state[i] == PASS) & ~full[i]));
        assign drop[i] = accept & active_en[i] & lossy_act[i] &
                         (state[i] == PASS) & full[i];
        assign valid_dst[i] = ~empty[i];
        assign drop_cnt[i*CNT_W +: CNT_W] = cnt[i];

        cr_axi4s_fanout_fifo #(
            .WIDTH (PAYLD_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .din   (payload_src),
            .pop   (ready_dst[i]),
            .dout  (payload_dst[i*PAYLD_WIDTH +: PAYLD_WIDTH]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
            for (int i = 0; i < N_OUTPUTS; i++) begin
                state[i] <= PASS;
                cnt[i]   <= '0;
            end
        end else begin
            event_q <= drop;
            for (int i = 0; i < N_OUTPUTS; i++) begin
                if (drop[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (!active_en[i] || !lossy_act[i]) begin
                    state[i] <= PASS;
                end else if (accept) begin
                    // A dropped tlast beat closes the frame, so only a mid-frame drop discards the tail.
                    if ((state[i] == PASS) && full[i] && !tlast) begin
                        state[i] <= DISCARD;
                    end else if ((state[i] == DISCARD) && tlast) begin
                        state[i] <= PASS;
                    end
                end
            end
        end
    end

endmodule

// File: doc/cr_axi4s_fanout_buf.md
# cr_axi4s_fanout_buf

Parametrised N-way AXI4-stream fanout for datapath output buses. It replaces the zero-buffer lockstep split slice between an engine core and its consumers (output register slice, interface monitor tap, debug taps). Each output has its own FIFO. Per output, software selects whether it is enabled and whether it is lossless, which back-pressures the source, or lossy, which drops whole frame tails instead of stalling. Lossy outputs report drops through saturating counters.

## Interface
Parameters:
- N_OUTPUTS, 2: number of destinations, 1..8.
- PAYLD_WIDTH, 64: payload bits per beat; tvalid is carried separately.
- TLAST_BIT, 0: index of tlast inside payload.
- DEPTH, 4: per-output FIFO depth; power of two, ≥2.
- CNT_W, 16: drop counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- valid_src  in  1  source beat valid.
- payload_src  in  PAYLD_WIDTH  source beat.
- ready_src  out  1  source beat accepted when valid_src & ready_src.
- valid_dst  out  N_OUTPUTS  per-output valid.
- payload_dst  out  N_OUTPUTS*PAYLD_WIDTH  per-output beat; output i occupies slice [i*PAYLD_WIDTH +: PAYLD_WIDTH].
- ready_dst  in  N_OUTPUTS  per-output ready.
- cfg_enable  in  N_OUTPUTS  output enable, quasi-static.
- cfg_lossy  in  N_OUTPUTS  1 = lossy tap, 0 = lossless, quasi-static.
- drop_cnt  out  N_OUTPUTS*CNT_W  per-output dropped-frame count; saturates at all-ones.
- drop_event  out  N_OUTPUTS  one-cycle pulse per dropped frame, for stat events.

## Operation
- **Accept.** A beat is accepted when valid_src & ready_src.
- **Ready.** ready_src = rst_done & AND over outputs (active_en[i] & !lossy_act[i] → !full[i]).
  - No combinational path from ready_dst to ready_src.
  - If every output is disabled or lossy, ready_src = rst_done.
- **Frame tracking.** in_frame is set by an accepted beat with tlast=0 and cleared by an accepted beat with tlast=1.
- **Config capture.** active_en[i] and lossy_act[i] load from cfg_* on any cycle where in_frame=0 and no beat is accepted. A configuration change never splits a frame.
- **Lossless, enabled output.** Every accepted beat is pushed to its FIFO.
- **Lossy, enabled output.** Each output i is in one of two states:
  - PASS: an accepted beat is pushed if !full[i].
    - If full[i], the beat is dropped and the output enters DISCARD. drop_event[i] pulses in the next cycle and drop_cnt[i] increments.
    - If that dropped beat carries tlast, the output stays in PASS.
  - DISCARD: all accepted beats are dropped. An accepted beat with tlast returns the output to PASS; that tlast beat is also dropped.
  - Beats of the frame already queued are still delivered, so a lossy consumer sees a truncated frame. Lossy taps are monitor-only.
- **Disabled output.** No push, no influence on ready_src, and its state is forced to PASS. Disabling does not flush its FIFO; queued beats still drain.
- **Drain.** valid_dst[i] = !empty[i]. The FIFO head is popped on valid_dst[i] & ready_dst[i]. Outputs drain independently.
- **Simultaneous push and pop.** Allowed at any occupancy below full; occupancy is unchanged. At full, push is blocked (lossless) or dropped (lossy) even if a pop occurs in the same cycle.
- **Counters.** drop_cnt holds at 2^CNT_W−1; drop_event still pulses when saturated.

## Timing
- **Reset values.**
  - FIFOs empty, so valid_dst=0.
  - ready_src=0, drop_cnt=0, drop_event=0.
  - in_frame=0, all outputs in PASS.
  - active_en and lossy_act = 0.
  - rst_done = 0, and it sets on the first clk edge after rst_n deasserts. ready_src can therefore first be 1 in the second cycle after release.
  - cfg is captured in the first idle cycle after reset.
- **Reset mid-frame.** Asserting rst_n low mid-frame drops all state immediately, including queued beats.
- **Latency.** A beat accepted at edge k is visible on valid_dst at k+1. There is no fall-through path.
- **Throughput.** One beat per cycle per output while ready_dst is held high.
- **payload_dst stability.** payload_dst[i] is stable while valid_dst[i] & !ready_dst[i]; FIFO memory is registered.
- **Handshake rules.** valid_src must not depend on ready_src; the block does not drop valid once asserted.

## Structure
- **Shared package:** the FIFO pointer/count typedef sized by $clog2(DEPTH)+1, and the lossy state enum (PASS, DISCARD).
- **Sub-module `cr_axi4s_fanout_fifo`:** one instance per output via generate. Contents:
  - synchronous-write register array;
  - wrapping read/write pointers with an extra wrap bit;
  - full and empty flags.
- The lossy state machine, counters and config capture stay in the top.

## Test plan
- **Reset and latency.** N=2, both lossless, ready_dst=11; stream a 5-beat frame → ready_src rises 2 cycles after reset release; each beat appears on both outputs 1 cycle after acceptance; throughput is 1 beat/cycle.
- **Lossless back-pressure.** DEPTH=4, ready_dst[1]=0 → output 1 fills after 4 beats and ready_src drops; output 0 receives exactly 4 beats; releasing ready_dst[1] resumes with no loss or reorder.
- **Lossy drop.** Output 1 lossy, ready_dst[1]=0, 10-beat frame → source never stalls; output 1 holds beats 0–3; drop_event[1] pulses once; drop_cnt[1]=1. The next frame is fully delivered once drained.
- **Config at frame boundary.** cfg_enable[1]: 1→0 asserted mid-frame → output 1 still receives the whole current frame and nothing of the next frame.
- **Counter saturation.** CNT_W=2, five dropped frames → drop_cnt=3 and 5 drop_event pulses.
- **Reset mid-frame.** rst_n pulsed low with beats queued → valid_dst=0 immediately; no stale beat appears after release.
